// File: rtl/rvvi_seq_pkg.sv
// Shared types and helpers for the RVVI retirement sequencer.
package rvvi_seq_pkg;

    // Sequencer FSM: wait for a pending hart, or stream that hart's slots.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } seq_state_e;

    // $clog2 that never yields zero, so a single hart/slot still gets a 1-bit index.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rvvi_rr_arbiter.sv
// Round-robin arbiter: grants the first requester strictly after ptr, wrapping around.
module rvvi_rr_arbiter import rvvi_seq_pkg::*; #(
    parameter  int NHART = 1,
    localparam int HW    = clog2_min1(NHART)
) (
    input  logic [NHART-1:0] req,
    input  logic [HW-1:0]    ptr,
    output logic [NHART-1:0] gnt,
    output logic [HW-1:0]    gnt_idx
);

    // Walk the ring starting one past ptr; the first requester seen wins.
    always_comb begin
        logic found;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 1; i <= NHART; i++) begin
            for (int j = 0; j < NHART; j++) begin
                if (!found && (j == (int'(ptr) + i) % NHART) && req[j]) begin
                    found   = 1'b1;
                    gnt[j]  = 1'b1;
                    gnt_idx = HW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/rvvi_retire_sequencer.sv
// Serialises per-hart RVVI retirement groups into one in-order record stream,
// checking each hart's order counter and tracking sticky halts.
module rvvi_retire_sequencer import rvvi_seq_pkg::*; #(
    parameter  int XLEN  = 32,
    parameter  int ILEN  = 32,
    parameter  int NHART = 1,
    parameter  int NRET  = 1,
    localparam int HW    = clog2_min1(NHART),
    localparam int SW    = clog2_min1(NRET)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NHART-1:0][NRET-1:0]            in_valid,
    input  logic [NHART-1:0][NRET-1:0][XLEN-1:0]  in_order,
    input  logic [NHART-1:0][NRET-1:0][ILEN-1:0]  in_insn,
    input  logic [NHART-1:0][NRET-1:0][XLEN-1:0]  in_pc,
    input  logic [NHART-1:0][NRET-1:0]            in_trap,
    input  logic [NHART-1:0][NRET-1:0]            in_halt,
    output logic [NHART-1:0]                      in_ready,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [HW-1:0]                         out_hart,
    output logic [SW-1:0]                         out_slot,
    output logic [XLEN-1:0]                       out_order,
    output logic [XLEN-1:0]                       out_pc,
    output logic [ILEN-1:0]                       out_insn,
    output logic                                  out_trap,
    output logic                                  out_halt,
    output logic                                  out_last,
    output logic                                  order_err,
    output logic [HW-1:0]                         err_hart,
    output logic [NHART-1:0]                      halted
);

    seq_state_e state;
    logic [HW-1:0]  cur, ptr;
    logic [NHART-1:0] pending, cap, expv, gnt;
    logic [HW-1:0]  gnt_idx;
    logic           drain, hs;

    // Per-hart registered state, gathered from the generate loop.
    logic [NRET-1:0]            mask_arr  [NHART];
    logic [XLEN-1:0]            exp_arr   [NHART];
    logic [NRET-1:0][XLEN-1:0]  order_arr [NHART];
    logic [NRET-1:0][XLEN-1:0]  pc_arr    [NHART];
    logic [NRET-1:0][ILEN-1:0]  insn_arr  [NHART];
    logic [NRET-1:0]            trap_arr  [NHART];
    logic [NRET-1:0]            halt_arr  [NHART];

    // Group of the hart currently being drained.
    logic [NRET-1:0]            cur_mask, cur_trap, cur_halt, slot_oh;
    logic [NRET-1:0][XLEN-1:0]  cur_order, cur_pc;
    logic [NRET-1:0][ILEN-1:0]  cur_insn;
    logic [XLEN-1:0]            cur_exp, rec_order, rec_pc;
    logic [ILEN-1:0]            rec_insn;
    logic                       cur_expv, rec_trap, rec_halt;
    logic [SW-1:0]              slot, hi_slot;

    assign in_ready = ~pending & ~halted;
    assign drain    = (state == DRAIN);
    assign hs       = out_valid & out_ready;

    rvvi_rr_arbiter #(.NHART(NHART)) u_arb (
        .req     (pending),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    for (genvar h = 0; h < NHART; h++) begin : g_hart
        logic                      pend_q, halt_q, expv_q, sel;
        logic [NRET-1:0]           mask_q, trap_q, hflag_q;
        logic [XLEN-1:0]           exp_q;
        logic [NRET-1:0][XLEN-1:0] order_q, pc_q;
        logic [NRET-1:0][ILEN-1:0] insn_q;

        assign cap[h] = in_ready[h] & (|in_valid[h]);
        assign sel    = hs && (cur == HW'(h));

        // Control: occupancy, slot mask, expected order and sticky halt for this hart.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pend_q <= 1'b0;
                mask_q <= '0;
                halt_q <= 1'b0;
                expv_q <= 1'b0;
                exp_q  <= '0;
            end else begin
                // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
                if (cap[h]) begin
                    pend_q <= 1'b1;
                    mask_q <= in_valid[h];
                end else if (sel) begin
                    mask_q <= mask_q & ~slot_oh;
                    if (out_last) pend_q <= 1'b0;
                end
                if (sel) begin
                    exp_q  <= out_order + XLEN'(1);
                    expv_q <= 1'b1;
                    if (out_halt) halt_q <= 1'b1;
                end
            end
        end

        // Payload capture for the whole group.
        // NOTE: payload storage has no reset; mask_q/pend_q decide whether any of it is ever read.
        always_ff @(posedge clk) begin
            if (cap[h]) begin
                order_q <= in_order[h];
                pc_q    <= in_pc[h];
                insn_q  <= in_insn[h];
                trap_q  <= in_trap[h];
                hflag_q <= in_halt[h];
            end
        end

        assign pending[h]   = pend_q;
        assign halted[h]    = halt_q;
        assign expv[h]      = expv_q;
        assign mask_arr[h]  = mask_q;
        assign exp_arr[h]   = exp_q;
        assign order_arr[h] = order_q;
        assign pc_arr[h]    = pc_q;
        assign insn_arr[h]  = insn_q;
        assign trap_arr[h]  = trap_q;
        assign halt_arr[h]  = hflag_q;
    end

    // Select the buffered group and order expectation of the current hart.
    always_comb begin
        cur_mask  = '0;
        cur_order = '0;
        cur_pc    = '0;
        cur_insn  = '0;
        cur_trap  = '0;
        cur_halt  = '0;
        cur_exp   = '0;
        cur_expv  = 1'b0;
        for (int h = 0; h < NHART; h++) begin
            if (cur == HW'(h)) begin
                cur_mask  = mask_arr[h];
                cur_order = order_arr[h];
                cur_pc    = pc_arr[h];
                cur_insn  = insn_arr[h];
                cur_trap  = trap_arr[h];
                cur_halt  = halt_arr[h];
                cur_exp   = exp_arr[h];
                cur_expv  = expv[h];
            end
        end
    end

    // Pick the lowest remaining slot and detect whether it is also the highest.
    always_comb begin
        slot      = '0;
        hi_slot   = '0;
        slot_oh   = '0;
        rec_order = '0;
        rec_pc    = '0;
        rec_insn  = '0;
        rec_trap  = 1'b0;
        rec_halt  = 1'b0;
        for (int i = NRET - 1; i >= 0; i--) begin
            if (cur_mask[i]) begin
                slot       = SW'(i);
                slot_oh    = '0;
                slot_oh[i] = 1'b1;
                rec_order  = cur_order[i];
                rec_pc     = cur_pc[i];
                rec_insn   = cur_insn[i];
                rec_trap   = cur_trap[i];
                rec_halt   = cur_halt[i];
            end
        end
        for (int i = 0; i < NRET; i++) begin
            if (cur_mask[i]) hi_slot = SW'(i);
        end
    end

    assign out_valid = drain;
    assign out_hart  = (drain && NHART > 1) ? cur : '0;
    assign out_slot  = (drain && NRET > 1) ? slot : '0;
    assign out_order = drain ? rec_order : '0;
    assign out_pc    = drain ? rec_pc : '0;
    assign out_insn  = drain ? rec_insn : '0;
    assign out_trap  = drain & rec_trap;
    assign out_halt  = drain & rec_halt;
    assign out_last  = drain & (slot == hi_slot);

    // Sequencer FSM plus the registered order-error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cur       <= '0;
            ptr       <= HW'(NHART - 1);
            order_err <= 1'b0;
            err_hart  <= '0;
        end else begin
            order_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        cur   <= gnt_idx;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (hs) begin
                        if (cur_expv && (out_order != cur_exp)) begin
                            order_err <= 1'b1;
                            err_hart  <= cur;
                        end
                        if (out_last) begin
                            ptr   <= cur;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rvvi_retire_sequencer.sv
// Self-checking bench: table-driven single-group vectors, directed multi-cycle
// sequences, and a randomized run against a queue-style reference model.
module tb_rvvi_retire_sequencer;
    localparam int XLEN  = 32;
    localparam int ILEN  = 32;
    localparam int NHART = 2;
    localparam int NRET  = 2;

    logic clk = 1'b0;
    logic reset;
    logic [NHART-1:0][NRET-1:0]           in_valid, in_trap, in_halt;
    logic [NHART-1:0][NRET-1:0][XLEN-1:0] in_order, in_pc;
    logic [NHART-1:0][NRET-1:0][ILEN-1:0] in_insn;
    logic [NHART-1:0] in_ready, halted;
    logic out_valid, out_ready, out_trap, out_halt, out_last, order_err;
    logic [0:0] out_hart, out_slot, err_hart;
    logic [XLEN-1:0] out_order, out_pc;
    logic [ILEN-1:0] out_insn;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rvvi_retire_sequencer #(.XLEN(XLEN), .ILEN(ILEN), .NHART(NHART), .NRET(NRET)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_order(in_order), .in_insn(in_insn), .in_pc(in_pc),
        .in_trap(in_trap), .in_halt(in_halt), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_hart(out_hart), .out_slot(out_slot),
        .out_order(out_order), .out_pc(out_pc), .out_insn(out_insn),
        .out_trap(out_trap), .out_halt(out_halt), .out_last(out_last),
        .order_err(order_err), .err_hart(err_hart), .halted(halted)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired before the expected event", name);
    endtask

    function automatic logic [XLEN-1:0] f_pc(input logic [XLEN-1:0] o);
        return (o << 2) + 32'h8000_0000;
    endfunction

    function automatic logic [ILEN-1:0] f_insn(input logic [XLEN-1:0] o);
        return (o * 32'd65536) | 32'h0000_0013;
    endfunction

    task automatic clear_inputs();
        in_valid = '0; in_order = '0; in_pc = '0; in_insn = '0; in_trap = '0; in_halt = '0;
    endtask

    task automatic drive_group(input int h, input logic [1:0] mask, input logic [31:0] o0,
                               input logic [31:0] o1, input logic [1:0] hmask, input logic [1:0] tmask);
        in_valid[h]    = mask;
        in_order[h][0] = o0;        in_order[h][1] = o1;
        in_pc[h][0]    = f_pc(o0);  in_pc[h][1]    = f_pc(o1);
        in_insn[h][0]  = f_insn(o0); in_insn[h][1] = f_insn(o1);
        in_halt[h]     = hmask;
        in_trap[h]     = tmask;
    endtask

    // Ends on a negedge with reset released and out_ready high.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Push one group when the hart is ready, then drain it with out_ready high.
    // Returns on the negedge right after the out_last handshake.
    task automatic xfer(input int h, input logic [1:0] mask, input logic [31:0] o0,
                        input logic [31:0] o1, input logic [1:0] hmask);
        int t = 0;
        while (!in_ready[h] && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) timeout_fail("xfer_ready");
        drive_group(h, mask, o0, o1, hmask, 2'b00);
        @(negedge clk);
        clear_inputs();
        t = 0;
        while (!(out_valid && out_ready && out_last) && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) timeout_fail("xfer_drain");
        @(negedge clk);
    endtask

    typedef struct {
        int          hart;
        logic [1:0]  mask;
        logic [31:0] o0, o1;
        logic [1:0]  trap;
        int          n;
        int          s0;
        logic        err;
    } vec_t;

    vec_t vt[5];

    // Reference-model state: per hart, the buffered records still to emit.
    typedef struct { logic [31:0] order; logic trap; int slot; } rec_t;
    rec_t        mrec [NHART][NRET];
    int          m_n [NHART], m_hd [NHART];
    logic        m_busy, m_err;
    int          m_cur, m_last, m_err_hart;
    logic [31:0] m_exp [NHART];
    logic        m_expv [NHART];
    logic [31:0] nxt_ord [NHART];

    initial begin
        reset = 1'b1;
        out_ready = 1'b1;
        clear_inputs();

        vt[0] = '{hart: 0, mask: 2'b11, o0: 32'd5,          o1: 32'd6,  trap: 2'b00, n: 2, s0: 0, err: 1'b0};
        vt[1] = '{hart: 1, mask: 2'b10, o0: 32'd0,          o1: 32'd9,  trap: 2'b10, n: 1, s0: 1, err: 1'b0};
        vt[2] = '{hart: 0, mask: 2'b01, o0: 32'd42,         o1: 32'd0,  trap: 2'b01, n: 1, s0: 0, err: 1'b0};
        vt[3] = '{hart: 1, mask: 2'b11, o0: 32'hFFFF_FFFF,  o1: 32'd0,  trap: 2'b00, n: 2, s0: 0, err: 1'b0};
        vt[4] = '{hart: 1, mask: 2'b11, o0: 32'd7,          o1: 32'd9,  trap: 2'b00, n: 2, s0: 0, err: 1'b1};

        // Reset state, observed while reset is held.
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 2'b11);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_order", out_order, 0);
        check("rst_out_last", out_last, 0);
        check("rst_order_err", order_err, 0);
        check("rst_err_hart", err_hart, 0);
        check("rst_halted", halted, 0);

        // Table-driven single-group vectors: latency N+2, slot order, last, order check.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            drive_group(vt[v].hart, vt[v].mask, vt[v].o0, vt[v].o1, 2'b00, vt[v].trap);
            @(negedge clk);               // cycle N+1: group pending, being granted
            clear_inputs();
            check($sformatf("v%0d_grant_cycle_valid", v), out_valid, 0);
            check($sformatf("v%0d_in_ready_busy", v), in_ready[vt[v].hart], 0);
            @(negedge clk);               // cycle N+2: first record
            for (int k = 0; k < vt[v].n; k++) begin
                int          s;
                logic [31:0] eo;
                s  = (k == 0) ? vt[v].s0 : 1;
                eo = (s == 0) ? vt[v].o0 : vt[v].o1;
                check($sformatf("v%0d_r%0d_valid", v, k), out_valid, 1);
                check($sformatf("v%0d_r%0d_hart", v, k), out_hart, vt[v].hart);
                check($sformatf("v%0d_r%0d_slot", v, k), out_slot, s);
                check($sformatf("v%0d_r%0d_order", v, k), out_order, eo);
                check($sformatf("v%0d_r%0d_pc", v, k), out_pc, f_pc(eo));
                check($sformatf("v%0d_r%0d_insn", v, k), out_insn, f_insn(eo));
                check($sformatf("v%0d_r%0d_trap", v, k), out_trap, vt[v].trap[s]);
                check($sformatf("v%0d_r%0d_last", v, k), out_last, (k == vt[v].n - 1));
                check($sformatf("v%0d_r%0d_err", v, k), order_err, 0);
                @(negedge clk);
            end
            check($sformatf("v%0d_final_err", v), order_err, vt[v].err);
            if (vt[v].err) check($sformatf("v%0d_err_hart", v), err_hart, vt[v].hart);
            check($sformatf("v%0d_idle_valid", v), out_valid, 0);
        end

        // Both harts pushing continuously alternate 0,1,0,1,0,1.
        begin
            int seen[$];
            int left[NHART];
            int t;
            do_reset();
            left[0] = 3; left[1] = 3; t = 0;
            while (seen.size() < 6 && t < 300) begin
                if (out_valid && out_ready) seen.push_back(int'(out_hart));
                for (int h = 0; h < NHART; h++) begin
                    if (in_ready[h] && left[h] > 0) begin
                        drive_group(h, 2'b01, 32'(100 * h + 3 - left[h]), 32'd0, 2'b00, 2'b00);
                        left[h]--;
                    end else begin
                        in_valid[h] = '0;
                    end
                end
                @(negedge clk);
                t++;
            end
            clear_inputs();
            if (seen.size() < 6) timeout_fail("alt_records");
            for (int i = 0; i < seen.size(); i++) check($sformatf("alt_hart_%0d", i), seen[i], i % 2);
            repeat (3) @(negedge clk);
            check("alt_no_err", order_err, 0);
        end

        // Order gap on hart 1: 3 then 5 errors, 6 then passes.
        do_reset();
        xfer(1, 2'b01, 32'd3, 32'd0, 2'b00);
        check("gap_first_ok", order_err, 0);
        xfer(1, 2'b01, 32'd5, 32'd0, 2'b00);
        check("gap_err_pulse", order_err, 1);
        check("gap_err_hart", err_hart, 1);
        @(negedge clk);
        check("gap_err_single_cycle", order_err, 0);
        xfer(1, 2'b01, 32'd6, 32'd0, 2'b00);
        check("gap_recover", order_err, 0);

        // Back-pressure: outputs hold for 4 cycles, then both records follow.
        begin
            int t;
            do_reset();
            out_ready = 1'b0;
            drive_group(0, 2'b11, 32'd20, 32'd21, 2'b00, 2'b01);
            @(negedge clk);
            clear_inputs();
            t = 0;
            while (!out_valid && t < 20) begin @(negedge clk); t++; end
            if (t >= 20) timeout_fail("stall_valid");
            for (int i = 0; i < 4; i++) begin
                check($sformatf("stall_valid_%0d", i), out_valid, 1);
                check($sformatf("stall_order_%0d", i), out_order, 32'd20);
                check($sformatf("stall_slot_%0d", i), out_slot, 0);
                check($sformatf("stall_trap_%0d", i), out_trap, 1);
                check($sformatf("stall_last_%0d", i), out_last, 0);
                check($sformatf("stall_ready_%0d", i), in_ready[0], 0);
                @(negedge clk);
            end
            out_ready = 1'b1;
            check("stall_rel_first", out_order, 32'd20);
            @(negedge clk);
            check("stall_second_order", out_order, 32'd21);
            check("stall_second_slot", out_slot, 1);
            check("stall_second_last", out_last, 1);
            check("stall_hart_still_busy", in_ready[0], 0);
            @(negedge clk);
            check("stall_done_valid", out_valid, 0);
            check("stall_hart_ready", in_ready[0], 1);
        end

        // Halt is sticky; reset mid-drain drops the output at once.
        begin
            int t;
            do_reset();
            xfer(0, 2'b01, 32'd100, 32'd0, 2'b01);
            check("halt_set", halted[0], 1);
            check("halt_ready_low", in_ready[0], 0);
            check("halt_other_ready", in_ready[1], 1);
            repeat (5) @(negedge clk);
            check("halt_sticky", halted[0], 1);
            check("halt_ready_sticky", in_ready[0], 0);
            out_ready = 1'b0;
            drive_group(1, 2'b11, 32'd50, 32'd51, 2'b00, 2'b00);
            @(negedge clk);
            clear_inputs();
            t = 0;
            while (!out_valid && t < 20) begin @(negedge clk); t++; end
            if (t >= 20) timeout_fail("midrst_valid");
            check("midrst_pre_valid", out_valid, 1);
            @(posedge clk);
            #2;
            reset = 1'b1;
            #1;
            check("midrst_valid_cleared", out_valid, 0);
            check("midrst_halted_cleared", halted, 0);
            check("midrst_in_ready", in_ready, 2'b11);
            @(negedge clk);
            reset = 1'b0;
            out_ready = 1'b1;
            repeat (3) begin
                @(negedge clk);
                check("midrst_no_output", out_valid, 0);
            end
        end

        // Randomized traffic against the reference model.
        do_reset();
        for (int h = 0; h < NHART; h++) begin
            m_n[h] = 0; m_hd[h] = 0; m_expv[h] = 1'b0; m_exp[h] = '0;
            nxt_ord[h] = 32'hFFFF_FFE0 + 32'(h * 8);
        end
        m_busy = 1'b0; m_cur = 0; m_last = NHART - 1; m_err = 1'b0; m_err_hart = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic m_rdy [NHART];
            // Compare the DUT against the model's view of this cycle.
            for (int h = 0; h < NHART; h++)
                check($sformatf("rnd%0d_in_ready%0d", cyc, h), in_ready[h], (m_hd[h] == m_n[h]));
            check($sformatf("rnd%0d_valid", cyc), out_valid, m_busy);
            if (m_busy) begin
                rec_t r;
                r = mrec[m_cur][m_hd[m_cur]];
                check($sformatf("rnd%0d_hart", cyc), out_hart, m_cur);
                check($sformatf("rnd%0d_slot", cyc), out_slot, r.slot);
                check($sformatf("rnd%0d_order", cyc), out_order, r.order);
                check($sformatf("rnd%0d_pc", cyc), out_pc, f_pc(r.order));
                check($sformatf("rnd%0d_insn", cyc), out_insn, f_insn(r.order));
                check($sformatf("rnd%0d_trap", cyc), out_trap, r.trap);
                check($sformatf("rnd%0d_last", cyc), out_last, (m_hd[m_cur] + 1 == m_n[m_cur]));
            end
            check($sformatf("rnd%0d_order_err", cyc), order_err, m_err);
            check($sformatf("rnd%0d_err_hart", cyc), err_hart, m_err_hart);

            // Drive new stimulus.
            out_ready = ($urandom_range(0, 3) != 0);
            clear_inputs();
            for (int h = 0; h < NHART; h++) begin
                logic [1:0]  mask;
                logic [31:0] o;
                mask = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(0, 3)) : 2'b00;
                o = nxt_ord[h] + (($urandom_range(0, 15) == 0) ? 32'd2 : 32'd0);
                for (int s = 0; s < NRET; s++) begin
                    if (mask[s]) begin
                        in_order[h][s] = o;
                        in_pc[h][s]    = f_pc(o);
                        in_insn[h][s]  = f_insn(o);
                        in_trap[h][s]  = 1'($urandom_range(0, 1));
                        o = o + 32'd1;
                    end
                end
                in_valid[h] = mask;
                if (mask != 2'b00 && m_hd[h] == m_n[h]) nxt_ord[h] = o;
            end

            @(posedge clk);
            // Advance the model across this edge using pre-edge state.
            for (int h = 0; h < NHART; h++) m_rdy[h] = (m_hd[h] == m_n[h]);
            m_err = 1'b0;
            if (m_busy) begin
                if (out_ready) begin
                    rec_t r;
                    r = mrec[m_cur][m_hd[m_cur]];
                    if (m_expv[m_cur] && r.order != m_exp[m_cur]) begin
                        m_err = 1'b1;
                        m_err_hart = m_cur;
                    end
                    m_exp[m_cur]  = r.order + 32'd1;
                    m_expv[m_cur] = 1'b1;
                    m_hd[m_cur]++;
                    if (m_hd[m_cur] == m_n[m_cur]) begin
                        m_busy = 1'b0;
                        m_last = m_cur;
                    end
                end
            end else begin
                for (int i = 1; i <= NHART; i++) begin
                    int c;
                    c = (m_last + i) % NHART;
                    if (!m_busy && m_hd[c] < m_n[c]) begin
                        m_busy = 1'b1;
                        m_cur = c;
                    end
                end
            end
            for (int h = 0; h < NHART; h++) begin
                if (m_rdy[h] && in_valid[h] != '0) begin
                    m_n[h] = 0;
                    m_hd[h] = 0;
                    for (int s = 0; s < NRET; s++) begin
                        if (in_valid[h][s]) begin
                            mrec[h][m_n[h]] = '{order: in_order[h][s], trap: in_trap[h][s], slot: s};
                            m_n[h]++;
                        end
                    end
                end
            end
            @(negedge clk);
            #0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rvvi_retire_sequencer.md
# rvvi_retire_sequencer

Serialises multi-hart, multi-slot retirement reports into one in-order record stream for a single trace consumer, such as a reference-model comparator. Each hart presents an NRET-wide retirement group. The block buffers one group per hart, picks harts round-robin, and emits the valid slots one per handshake in ascending slot order. It also checks each hart's order counter for gaps or reuse and tracks halts.

## Interface
Parameters:
- XLEN, 32, order/PC width
- ILEN, 32, instruction width
- NHART, 1, number of harts
- NRET, 1, retire slots per hart per cycle
- HW = max(1, $clog2(NHART)); SW = max(1, $clog2(NRET)), derived

Ports (per-hart/slot signals are packed [NHART-1:0][NRET-1:0] of the stated element width):
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  NHART×NRET×1  slot retired
- in_order  in  NHART×NRET×XLEN  instruction order count
- in_insn  in  NHART×NRET×ILEN  instruction bits
- in_pc  in  NHART×NRET×XLEN  pc_rdata
- in_trap, in_halt  in  NHART×NRET×1  trap / halt flags
- in_ready  out  NHART  hart group may be accepted
- out_valid  out  1  record available
- out_ready  in  1  consumer accepts
- out_hart  out  HW  source hart
- out_slot  out  SW  source slot
- out_order, out_pc  out  XLEN  record fields
- out_insn  out  ILEN  record field
- out_trap, out_halt  out  1  record flags
- out_last  out  1  final record of the hart's group
- order_err  out  1  single-cycle order violation pulse
- err_hart  out  HW  hart that raised the last order_err
- halted  out  NHART  sticky halt per hart

## Operation
- **Capture.** in_ready[h] = ~pending[h] & ~halted[h]. When in_ready[h] is 1 and any in_valid[h][*] is 1, the whole group is registered into buf[h], mask[h] is set to in_valid[h], and pending[h] is set to 1. An all-zero group is ignored.
- **FSM states.**
  - IDLE: if any pending[h], the arbiter grants the first pending hart after ptr, in circular order. Then cur = grant, and the state goes to DRAIN.
  - DRAIN: out_valid = 1. The record is buf[cur] at s = lowest set bit of mask[cur]. out_last = 1 when s is the highest set bit.
  - On out_valid & out_ready: clear mask[cur][s]. If out_last: clear pending[cur], set ptr = cur, go to IDLE.
- **Order check (on each handshake):**
  - If exp_v[h] = 1 and out_order != exp[h]: order_err = 1 next cycle, and err_hart = h.
  - Always set exp[h] = out_order + 1 (mod 2^XLEN) and exp_v[h] = 1.
- **Halt.** A handshaken record with out_halt = 1 sets halted[h]. halted[h] holds until reset, so in_ready[h] stays 0.
- Trap records are passed through with no special handling.

## Timing
- Reset values:
  - in_ready = all 1; out_valid = 0; out_* = 0; out_last = 0.
  - order_err = 0; err_hart = 0; halted = 0.
  - pending = 0; exp_v = 0; ptr = NHART-1 (so hart 0 wins first); FSM = IDLE.
- Latency: a group accepted at edge N becomes pending after N and is granted in cycle N+1. Its first record has out_valid high in cycle N+2.
- Throughput: one record per cycle within a group, with one idle cycle between groups.
- Output hold: while out_valid & ~out_ready, all out_* are stable and no new grant occurs.
- New groups may be captured for other harts during DRAIN. Hart cur cannot capture until the cycle after its out_last handshake.
- Reset asserted mid-drain discards all buffered records. No partial output follows.
- Order wrap: exp = 2^XLEN-1 followed by order 0 is legal.
- NHART = 1 / NRET = 1: out_hart and out_slot are tied to 0.

## Structure
- Package rvvi_seq_pkg holds:
  - state enum {IDLE, DRAIN};
  - function clog2_min1().
- Sub-module rvvi_rr_arbiter (NHART): inputs req and ptr; outputs one-hot gnt and its index. It is purely combinational and instantiated once.
- The per-hart buffer, mask and expected-order registers are generate-loop arrays.

## Test plan
- NHART=1, NRET=2, group {order 5, order 6}, out_ready=1 -> records 5 (slot 0) and 6 (slot 1, out_last) in cycles N+2 and N+3; order_err stays 0.
- NHART=2, NRET=1, both harts push at once -> hart 0 is emitted first, then hart 1. Repeating gives alternating 0, 1, 0, 1.
- Valid mask 2'b10, order 9 -> a single record with out_slot = 1 and out_last = 1.
- Hart order sequence 3, then 5 -> order_err pulses one cycle after the second handshake with err_hart = that hart. A following 6 gives no error.
- out_ready held low 4 cycles -> out_* remain constant and in_ready of the draining hart stays 0. Releasing out_ready resumes with no loss.
- Record with halt=1 -> halted[h] = 1 and in_ready[h] = 0 permanently. Asserting reset during a later DRAIN clears out_valid immediately.
